// File: rtl/npc_pkg.sv
// Shared types and constants for the npc multi-cycle control sequencer.
package npc_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [XLEN-1:0] EBREAK_INST      = 32'h0010_0073;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4,
    ST_ERR   = 3'd5
  } npc_state_e;

  // Instruction fetch requires word alignment.
  function automatic logic pc_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/npc_wait_timer.sv
// Consecutive-wait counter shared by the FETCH and MEM handshakes.
module npc_wait_timer #(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired_c
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_MAX - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // High while the current wait cycle is the last one allowed.
  assign expired_c = (cnt == LAST);

endmodule

// File: rtl/npc_seq.sv
// Multi-cycle control sequencer: owns PC and instruction latch, steps each
// instruction through FETCH/EXEC/MEM/WB with handshake waits and halt/error exits.
module npc_seq
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req,
  output logic [31:0] ifu_addr,
  input  logic        ifu_rvalid,
  input  logic [31:0] ifu_rdata,
  output logic [31:0] inst,
  input  logic        is_mem,
  input  logic        reg_wen_in,
  output logic        reg_wen,
  output logic        lsu_req,
  input  logic        lsu_done,
  input  logic [31:0] next_pc,
  output logic [31:0] pc,
  output logic        ebreak_pulse,
  output logic        halted,
  output logic        error,
  output logic [31:0] retired
);

  npc_state_e  state, state_d;
  logic [31:0] pc_d, inst_d, retired_d;
  logic        halted_d, error_d, ebreak_d;
  logic        tmr_clr, tmr_inc, tmr_exp_c;

  npc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
    .clk       (clk),
    .rst       (rst),
    .clr       (tmr_clr),
    .inc       (tmr_inc),
    .expired_c (tmr_exp_c)
  );

  assign ifu_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_FETCH;
      pc           <= RESET_PC;
      inst         <= '0;
      retired      <= '0;
      halted       <= 1'b0;
      error        <= 1'b0;
      ebreak_pulse <= 1'b0;
      ifu_req      <= 1'b1;
      lsu_req      <= 1'b0;
    end else begin
      state        <= state_d;
      pc           <= pc_d;
      inst         <= inst_d;
      retired      <= retired_d;
      halted       <= halted_d;
      error        <= error_d;
      ebreak_pulse <= ebreak_d;
      ifu_req      <= (state_d == ST_FETCH);
      lsu_req      <= (state_d == ST_MEM);
    end
  end

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    inst_d    = inst;
    retired_d = retired;
    halted_d  = halted;
    error_d   = error;
    ebreak_d  = 1'b0;
    tmr_clr   = 1'b1;
    tmr_inc   = 1'b0;
    reg_wen   = 1'b0;

    unique case (state)
      ST_FETCH: begin
        if (ifu_rvalid) begin
          inst_d  = ifu_rdata;
          state_d = ST_EXEC;
        end else begin
          tmr_clr = 1'b0;
          tmr_inc = 1'b1;
          if (tmr_exp_c) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (inst == EBREAK_INST) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
          ebreak_d = 1'b1;
        end else if (is_mem) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (lsu_done) begin
          state_d = ST_WB;
        end else begin
          tmr_clr = 1'b0;
          tmr_inc = 1'b1;
          if (tmr_exp_c) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end
        end
      end
      ST_WB: begin
        // A misaligned target is trapped before it can reach the fetch port.
        if (pc_aligned(next_pc)) begin
          reg_wen   = reg_wen_in;
          pc_d      = next_pc;
          retired_d = retired + 32'd1;
          state_d   = ST_FETCH;
        end else begin
          state_d = ST_ERR;
          error_d = 1'b1;
        end
      end
      ST_HALT, ST_ERR: begin
      end
      default: begin
        state_d = ST_ERR;
        error_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_npc_seq.sv
// Self-checking bench for npc_seq: directed scenarios plus randomized
// instruction streams against an instruction-level reference model.
module tb_npc_seq;
  import npc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ifu_req, ifu_rvalid, is_mem, reg_wen_in, reg_wen, lsu_req, lsu_done;
  logic        ebreak_pulse, halted, error;
  logic [31:0] ifu_addr, ifu_rdata, inst, next_pc, pc, retired;

  logic        ifu_req_t, ifu_rvalid_t, is_mem_t, reg_wen_in_t, reg_wen_t, lsu_req_t, lsu_done_t;
  logic        ebreak_pulse_t, halted_t, error_t;
  logic [31:0] ifu_addr_t, ifu_rdata_t, inst_t, next_pc_t, pc_t, retired_t;

  npc_seq dut (
    .clk(clk), .rst(rst), .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_rvalid(ifu_rvalid),
    .ifu_rdata(ifu_rdata), .inst(inst), .is_mem(is_mem), .reg_wen_in(reg_wen_in),
    .reg_wen(reg_wen), .lsu_req(lsu_req), .lsu_done(lsu_done), .next_pc(next_pc), .pc(pc),
    .ebreak_pulse(ebreak_pulse), .halted(halted), .error(error), .retired(retired)
  );

  npc_seq #(.WAIT_MAX(4)) dut_t (
    .clk(clk), .rst(rst), .ifu_req(ifu_req_t), .ifu_addr(ifu_addr_t), .ifu_rvalid(ifu_rvalid_t),
    .ifu_rdata(ifu_rdata_t), .inst(inst_t), .is_mem(is_mem_t), .reg_wen_in(reg_wen_in_t),
    .reg_wen(reg_wen_t), .lsu_req(lsu_req_t), .lsu_done(lsu_done_t), .next_pc(next_pc_t),
    .pc(pc_t), .ebreak_pulse(ebreak_pulse_t), .halted(halted_t), .error(error_t),
    .retired(retired_t)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Architectural view of the sequencer, advanced once per instruction.
  logic [31:0] m_pc, m_inst, m_retired;
  bit          m_halted, m_error;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    rst        = 1'b0;
    ifu_rvalid = 1'($urandom);
    ifu_rdata  = $urandom;
    is_mem     = 1'($urandom);
    reg_wen_in = 1'($urandom);
    lsu_done   = 1'($urandom);
    next_pc    = $urandom;
  endtask

  task automatic check_cycle(input string ph, input bit e_ifu, input bit e_lsu,
                             input bit e_wen, input bit e_ebk);
    chk({ph, ".ifu_req"},  32'(ifu_req),      32'(e_ifu));
    chk({ph, ".lsu_req"},  32'(lsu_req),      32'(e_lsu));
    chk({ph, ".reg_wen"},  32'(reg_wen),      32'(e_wen));
    chk({ph, ".ebreak"},   32'(ebreak_pulse), 32'(e_ebk));
    chk({ph, ".pc"},       pc,                m_pc);
    chk({ph, ".ifu_addr"}, ifu_addr,          m_pc);
    chk({ph, ".retired"},  retired,           m_retired);
    chk({ph, ".halted"},   32'(halted),       32'(m_halted));
    chk({ph, ".error"},    32'(error),        32'(m_error));
  endtask

  task automatic model_reset();
    m_pc = RESET_PC_DEFAULT; m_inst = '0; m_retired = '0; m_halted = 1'b0; m_error = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    drive_idle();
    rst = 1'b1; ifu_rvalid = 1'b1; lsu_done = 1'b1; reg_wen_in = 1'b1;
    model_reset();
    @(negedge clk);
    drive_idle();
    ifu_rvalid = 1'b0;
    #1;
    check_cycle("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset.inst", inst, 32'h0);
  endtask

  // One instruction: fd fetch waits, optional MEM with md waits, then WB to npc.
  // rst_at >= 0 asserts rst (with lsu_done) in that MEM cycle instead of finishing.
  task automatic run_instr(input logic [31:0] w, input int fd, input bit mem, input int md,
                           input bit wen, input logic [31:0] npc, input int rst_at);
    bit aligned;
    for (int k = 0; k <= fd; k++) begin
      @(negedge clk); drive_idle();
      ifu_rvalid = (k == fd);
      ifu_rdata  = (k == fd) ? w : $urandom;
      #1;
      check_cycle("fetch", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("fetch.inst_hold", inst, m_inst);
    end
    m_inst = w;
    @(negedge clk); drive_idle(); is_mem = mem; reg_wen_in = 1'b1; #1;
    check_cycle("exec", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("exec.inst", inst, m_inst);
    if (w == EBREAK_INST) begin
      m_halted = 1'b1;
      @(negedge clk); drive_idle(); reg_wen_in = 1'b1; #1;
      check_cycle("halt1", 1'b0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk); drive_idle(); reg_wen_in = 1'b1; ifu_rvalid = 1'b1; #1;
        check_cycle("halt", 1'b0, 1'b0, 1'b0, 1'b0);
      end
      return;
    end
    if (mem) begin
      for (int k = 0; k <= md; k++) begin
        @(negedge clk); drive_idle();
        lsu_done = (k == md);
        if (k == rst_at) begin rst = 1'b1; lsu_done = 1'b1; reg_wen_in = 1'b1; end
        #1;
        check_cycle("mem", 1'b0, 1'b1, 1'b0, 1'b0);
        if (k == rst_at) begin
          model_reset();
          @(negedge clk); drive_idle(); ifu_rvalid = 1'b0; reg_wen_in = 1'b1; #1;
          check_cycle("post_rst", 1'b1, 1'b0, 1'b0, 1'b0);
          chk("post_rst.inst", inst, 32'h0);
          return;
        end
      end
    end
    @(negedge clk); drive_idle(); next_pc = npc; reg_wen_in = wen; #1;
    aligned = (npc[1:0] == 2'b00);
    check_cycle("wb", 1'b0, 1'b0, aligned && wen, 1'b0);
    if (aligned) begin
      m_pc = npc;
      m_retired = m_retired + 32'd1;
    end else begin
      m_error = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk); drive_idle(); reg_wen_in = 1'b1; ifu_rvalid = 1'b1; lsu_done = 1'b1; #1;
        check_cycle("err", 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic step_t(input bit rv, input bit mem, input bit done, input logic [31:0] npc);
    @(negedge clk);
    rst = 1'b0;
    ifu_rvalid_t = rv; ifu_rdata_t = 32'h0000_0013; is_mem_t = mem;
    lsu_done_t = done; next_pc_t = npc; reg_wen_in_t = 1'b1;
    #1;
  endtask

  initial begin
    logic [31:0] w, r, npc;
    int          fd, md, rst_at;
    bit          mem;

    rst = 1'b1;
    ifu_rvalid = 1'b0; ifu_rdata = '0; is_mem = 1'b0; reg_wen_in = 1'b0; lsu_done = 1'b0;
    next_pc = '0;
    ifu_rvalid_t = 1'b0; ifu_rdata_t = '0; is_mem_t = 1'b0; reg_wen_in_t = 1'b0;
    lsu_done_t = 1'b0; next_pc_t = '0;

    // Three back-to-back ALU instructions, zero-latency fetch.
    reset_dut();
    for (int i = 0; i < 3; i++) run_instr(32'h0000_0013 + 32'(i << 7), 0, 1'b0, 0, 1'b1, m_pc + 32'd4, -1);
    @(negedge clk); drive_idle(); ifu_rvalid = 1'b0; #1;
    chk("alu3.retired", retired, 32'd3);
    chk("alu3.pc", pc, 32'h8000_000C);

    run_instr(32'h0040_0093, 5, 1'b0, 0, 1'b1, m_pc + 32'd4, -1);
    run_instr(32'h0000_2103, 0, 1'b1, 2, 1'b1, m_pc + 32'd4, -1);
    run_instr(32'h0000_0013, 0, 1'b0, 0, 1'b1, 32'h8000_0002, -1);

    reset_dut();
    run_instr(EBREAK_INST, 0, 1'b1, 0, 1'b1, 32'h0, -1);

    reset_dut();
    run_instr(32'h0000_2103, 0, 1'b1, 3, 1'b1, m_pc + 32'd4, 1);

    // Randomized instruction stream.
    for (int i = 0; i < 60; i++) begin
      if (m_error || m_halted) reset_dut();
      w = $urandom;
      if (w == EBREAK_INST) w = 32'h0000_0013;
      if ($urandom_range(0, 15) == 0) w = EBREAK_INST;
      fd  = $urandom_range(0, 4);
      mem = 1'($urandom);
      md  = $urandom_range(0, 3);
      r   = $urandom;
      npc = {r[31:2], 2'b00};
      if ($urandom_range(0, 9) == 0) npc = {r[31:2], 2'($urandom_range(1, 3))};
      rst_at = (mem && $urandom_range(0, 7) == 0) ? $urandom_range(0, md) : -1;
      run_instr(w, fd, mem, md, 1'($urandom), npc, rst_at);
    end

    // WAIT_MAX=4 instance: a response on the 4th cycle is still in time.
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step_t(1'b0, 1'b0, 1'b0, 32'h0);
      chk("t.fetch_wait.req", 32'(ifu_req_t), 32'd1);
      chk("t.fetch_wait.err", 32'(error_t), 32'd0);
    end
    step_t(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t.fetch4.req", 32'(ifu_req_t), 32'd1);
    step_t(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t.exec.inst", inst_t, 32'h0000_0013);
    chk("t.exec.err", 32'(error_t), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step_t(1'b0, 1'b0, 1'b0, 32'h0);
      chk("t.mem_wait.req", 32'(lsu_req_t), 32'd1);
      chk("t.mem_wait.err", 32'(error_t), 32'd0);
    end
    step_t(1'b0, 1'b0, 1'b1, 32'h0);
    chk("t.mem4.req", 32'(lsu_req_t), 32'd1);
    step_t(1'b0, 1'b0, 1'b0, 32'h8000_0004);
    chk("t.wb.wen", 32'(reg_wen_t), 32'd1);
    // Four silent fetch cycles exhaust the budget.
    for (int k = 0; k < 4; k++) begin
      step_t(1'b0, 1'b0, 1'b0, 32'h0);
      chk("t.to.req", 32'(ifu_req_t), 32'd1);
      chk("t.to.err", 32'(error_t), 32'd0);
      chk("t.to.addr", ifu_addr_t, 32'h8000_0004);
      chk("t.to.retired", retired_t, 32'd1);
    end
    step_t(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t.fetch_to.err", 32'(error_t), 32'd1);
    chk("t.fetch_to.req", 32'(ifu_req_t), 32'd0);
    chk("t.fetch_to.pc", pc_t, 32'h8000_0004);
    chk("t.fetch_to.halted", 32'(halted_t), 32'd0);
    chk("t.fetch_to.ebreak", 32'(ebreak_pulse_t), 32'd0);

    // MEM timeout on the same instance.
    @(negedge clk); rst = 1'b1;
    step_t(1'b1, 1'b0, 1'b0, 32'h0);
    step_t(1'b0, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step_t(1'b0, 1'b0, 1'b0, 32'h0);
      chk("t.mto.req", 32'(lsu_req_t), 32'd1);
      chk("t.mto.err", 32'(error_t), 32'd0);
    end
    step_t(1'b0, 1'b0, 1'b1, 32'h0);
    chk("t.mem_to.err", 32'(error_t), 32'd1);
    chk("t.mem_to.req", 32'(lsu_req_t), 32'd0);
    chk("t.mem_to.wen", 32'(reg_wen_t), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/npc_seq.md
# npc_seq

Multi-cycle control sequencer for the npc core. It owns the PC and the fetched-instruction latch. It runs each instruction through fetch, execute, optional memory and writeback phases, with valid/ready-style waits on instruction and data memory. It gates the register-file write enable to the writeback cycle and handles ebreak halt, wait timeouts and misaligned-PC errors, replacing the free-running single-cycle PC increment.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- WAIT_MAX, 255, maximum consecutive wait cycles in FETCH or MEM before ERR (1..65535)

Ports:
- clk  in  1  single clock for the block
- rst  in  1  synchronous, active-high reset
- ifu_req  out  1  instruction fetch request, level-held while in FETCH
- ifu_addr  out  32  fetch address, always equals pc
- ifu_rvalid  in  1  fetch data valid; may assert in the same cycle as ifu_req
- ifu_rdata  in  32  fetched instruction
- inst  out  32  latched instruction, fed to the decoder
- is_mem  in  1  decoder flag for a load or store in inst
- reg_wen_in  in  1  decoder register-write request
- reg_wen  out  1  gated register-file write enable
- lsu_req  out  1  data-memory request, level-held while in MEM
- lsu_done  in  1  data access complete
- next_pc  in  32  PC computed by the datapath for the current inst
- pc  out  32  architectural PC
- ebreak_pulse  out  1  one-cycle pulse on halt entry, drives the DPI ebreak hook
- halted  out  1  sticky; set by ebreak
- error  out  1  sticky; set by timeout or misaligned next_pc
- retired  out  32  count of completed instructions, wraps modulo 2^32

## Operation
- States: FETCH, EXEC, MEM, WB, HALT, ERR.
- Reset values: state=FETCH, pc=RESET_PC, inst=0, retired=0, halted=0, error=0, ebreak_pulse=0, wait counter=0.
- FETCH
  - ifu_req=1.
  - On ifu_rvalid: inst<=ifu_rdata, go to EXEC, clear the wait counter.
  - Otherwise the counter increments. When it reaches WAIT_MAX, go to ERR.
- EXEC
  - One cycle; inst is stable for the decoder and datapath.
  - If inst==32'h0010_0073 (EBREAK): go to HALT, with ebreak_pulse=1 on the next cycle only. pc is unchanged and there is no register write.
  - Otherwise, if is_mem: go to MEM.
  - Otherwise: go to WB.
- MEM
  - lsu_req=1.
  - On lsu_done: go to WB.
  - The same timeout rule as FETCH applies.
- WB
  - If next_pc[1:0]==0:
    - reg_wen=reg_wen_in (combinational, this cycle only).
    - pc<=next_pc, retired<=retired+1, go to FETCH.
  - Otherwise: reg_wen=0, pc is held, go to ERR.
- HALT and ERR are absorbing; only rst leaves them. ifu_req, lsu_req and reg_wen are 0 in both states.
- ifu_rvalid outside FETCH and lsu_done outside MEM are ignored.
- rst in any state, including mid-wait, overrides everything; the next cycle is FETCH at RESET_PC.
- reg_wen is 0 in every state except WB.

## Timing
- Zero-latency memory:
  - ALU instruction: 3 cycles (FETCH, EXEC, WB).
  - Load/store: 4 cycles (FETCH, EXEC, MEM, WB).
- Each cycle without ifu_rvalid in FETCH, or without lsu_done in MEM, adds exactly one cycle.
- pc and retired update on the clock edge that ends WB; ifu_addr shows the new PC in the following FETCH cycle.
- ebreak_pulse is high exactly one cycle: the first cycle in HALT. halted rises in that same cycle.
- Timeout: ERR is entered on the edge after the WAIT_MAXth consecutive cycle without a response; error rises on that edge.

## Structure
- Shared package npc_pkg holds:
  - the state enum (3-bit encoding)
  - the EBREAK constant 32'h0010_0073
  - the RESET_PC default
- Sub-module npc_wait_timer: clear/increment counter with an expired flag, parameterized by WAIT_MAX, and shared by FETCH and MEM.
- The FSM, PC register and inst latch stay in npc_seq.

## Test plan
- Reset, then three ALU instructions with rvalid in the same cycle as req and next_pc=pc+4:
  - pc: 0x8000_0000 → 0x8000_0004 → 0x8000_0008 → 0x8000_000C
  - 3 cycles each, retired=3
  - reg_wen high only in the WB cycles
- Fetch with rvalid delayed 5 cycles: ifu_req is held for 6 cycles, ifu_addr is stable, and inst latches only on rvalid.
- Load with lsu_done after 2 cycles: MEM lasts 3 cycles, reg_wen pulses once, and the instruction totals 6 cycles.
- Fetch of 32'h0010_0073:
  - ebreak_pulse for exactly 1 cycle, then halted=1
  - pc unchanged, no reg_wen, no further ifu_req
- Error paths:
  - WAIT_MAX=4 with ifu_rvalid held low: error=1 after the 4th wait cycle.
  - Separately, next_pc=0x8000_0002: error=1, pc stays, reg_wen=0.
- rst asserted mid-MEM, with lsu_done arriving in the same cycle: the next cycle is FETCH at 0x8000_0000, retired=0, and there is no write.
